seq_chunk_adder: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/seq_chunk_adder_slice.sv | 35 +++
 rtl/seq_chunk_adder.sv | 110 +++++++++++
 tb/tb_seq_chunk_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, add/sub select
// constants, adder FSM states and a sizing helper.
package alu_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sca_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_slice.sv
// Combinational CHUNK-bit ripple-carry slice; also
// exposes the carry into its MSB for overflow detection.
module rca_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             ci,
  output logic [CHUNK-1:0] s_chunk,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK:0]   c;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign p[i]       = a_chunk[i] ^ b_chunk[i];
    assign g[i]       = a_chunk[i] & b_chunk[i];
    assign s_chunk[i] = p[i] ^ c[i];
  end

  // Ripple kept in one process so the chain is evaluated in order.
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice
// per clock, LSB chunk first, carry held in a register.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import alu_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  sca_state_e state;
  sca_state_e state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] s_ext;
  logic             carry;
  logic [CW-1:0]    k;
  logic [CHUNK-1:0] s_chunk;
  logic             co;
  logic             c_msb;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = (k == CW'(NCHUNK - 1));
  assign busy   = (state == RUN);

  // Operands shift right so the slice always sees bits [CHUNK-1:0];
  // results enter the accumulator from the top.
  assign s_ext    = WIDTH'(s_chunk);
  assign acc_next = (acc >> CHUNK) | (s_ext << (WIDTH - CHUNK));

  rca_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a_chunk  (a_q[CHUNK-1:0]),
    .b_chunk  (b_q[CHUNK-1:0]),
    .ci       (carry),
    .s_chunk  (s_chunk),
    .co       (co),
    .c_msb_in (c_msb)
  );

  always_comb begin
    state_next = state;
    unique case (1'b1)
      (state == IDLE): if (start) state_next = RUN;
      (state == RUN):  if (last)  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= (sub == SEL_SUB) ? ~b : b;
        carry <= cin ^ sub;
        k     <= '0;
        acc   <= '0;
      end else if (state == RUN) begin
        a_q   <= a_q >> CHUNK;
        b_q   <= b_q >> CHUNK;
        acc   <= acc_next;
        carry <= co;
        k     <= k + CW'(1);
        if (last) begin
          sum  <= acc_next;
          cout <= co;
          ovf  <= c_msb ^ co;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: four adder instances (CHUNK 8,1,4,32),
// expected results queued at issue, checked on done.
module tb_seq_chunk_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic [31:0] sum [4];
  logic [3:0]  cout;
  logic [3:0]  ovf;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat_tab [4] = '{5, 33, 9, 2};
  exp_t sb [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy[0]), .done(done[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy[1]), .done(done[1]),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy[2]), .done(done[2]),
    .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2])
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy[3]), .done(done[3]),
    .sum(sum[3]), .cout(cout[3]), .ovf(ovf[3])
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          chk($sformatf("sum[%0d]", i), 64'(sum[i]), 64'(e.sum));
          chk($sformatf("cout[%0d]", i), 64'(cout[i]), 64'(e.cout));
          chk($sformatf("ovf[%0d]", i), 64'(ovf[i]), 64'(e.ovf));
          chk($sformatf("latency[%0d]", i), 64'(cyc - e.t0), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] ta,
                       input logic [31:0] tb, input logic tc,
                       input logic ts, input logic [31:0] es,
                       input logic ec, input logic eo);
    exp_t e;
    a = ta; b = tb; cin = tc; sub = ts;
    start_v[i] = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    e.lat = lat_tab[i]; e.t0 = cyc;
    sb[i].push_back(e);
  endtask

  task automatic run_op(input int i, input logic [31:0] ta,
                        input logic [31:0] tb, input logic tc,
                        input logic ts, input logic [31:0] es,
                        input logic ec, input logic eo);
    int w = 0;
    @(negedge clk);
    while (busy[i] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy[i]) chk("idle_timeout", 64'd1, 64'd0);
    issue(i, ta, tb, tc, ts, es, ec, eo);
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic drain();
    int w = 0;
    int pend;
    pend = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    while (pend != 0 && w < 200) begin
      @(negedge clk);
      w++;
      pend = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    end
    if (pend != 0) chk("drain_timeout", 64'(pend), 64'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; start_v = '1; sub = 1'b0; cin = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum[0]), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0; start_v = '0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op(0, 32'd10, 32'd3, 1'b1, 1'b1, 32'h6, 1'b1, 1'b0);
    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
           32'h2345_678A, 1'b0, 1'b0);
    drain();

    // Start pulsed while busy must be dropped.
    run_op(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0,
           32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 1'b0; cin = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    drain();
    repeat (8) @(negedge clk);
    chk("ignored_start_sum", 64'(sum[0]), 64'hFFFF_FFFF);
    chk("ignored_start_busy", 64'(busy[0]), 64'd0);

    // Back-to-back: second start issued in the done cycle.
    run_op(0, 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
    w = 0;
    while (!done[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!done[0]) chk("b2b_done_timeout", 64'd1, 64'd0);
    issue(0, 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 1'b0,
          32'h1F1F_1F1F, 1'b0, 1'b0);
    @(negedge clk);
    start_v = '0;
    chk("b2b_busy", 64'(busy[0]), 64'd1);
    @(negedge clk);
    chk("b2b_hold_sum", 64'(sum[0]), 64'd3);
    drain();

    // Reset on the second edge after accept aborts the op.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1; sub = 1'b0; cin = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_sum", 64'(sum[0]), 64'd0);
    chk("abort_cout", 64'(cout[0]), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_done_busy", 64'(busy[0]), 64'd0);

    // Same add/sub cases on the other chunk sizes.
    for (int i = 1; i < 4; i++) begin
      run_op(i, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      run_op(i, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
      run_op(i, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
             32'h2345_678A, 1'b0, 1'b0);
      run_op(i, 32'h8000_0000, 32'h1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1);
      drain();
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
